// File: rtl/fpu_cast_scheduler.sv
// fpu_cast_scheduler
//   Shares one combinational 32-bit integer -> IEEE-754 single-precision cast
//   (round-to-nearest, ties-to-even) between two requesters. One operation is
//   in flight at a time: IDLE grants and captures an operand, CONVERT waits
//   EXTRA_CYCLES cycles and then registers the cast, and RESPOND holds the
//   result until the owning requester takes it. When both requesters are
//   valid, the grant alternates between them.
//
// Ports
//   clk                           rising-edge clock
//   clr                           asynchronous active-low reset
//   req_valid[1:0]                requester i presents an operand
//   req_ready[1:0]                requester i's operand is accepted this cycle
//   req_operand0, req_operand1    32-bit integer operands
//   req_signed[1:0]               1 = two's complement, 0 = unsigned
//   resp_valid[1:0]               result available for requester i
//   resp_ready[1:0]               requester i takes the result
//   resp_result[31:0]             shared single-precision result
//   busy                          high whenever the block is not idle
module fpu_cast_scheduler #(
  parameter int unsigned EXTRA_CYCLES = 0   // legal range 0..7
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_operand0,
  input  logic [31:0] req_operand1,
  input  logic [1:0]  req_signed,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, RESPOND} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_owner_reg, last_owner_next;
  logic        sgn_reg, sgn_next;
  logic [31:0] opnd_reg, opnd_next;
  logic [31:0] result_reg, result_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic [1:0]  grant;
  logic [31:0] cast_result;

  // Arbitration: a lone requester wins; on a tie the requester that was not
  // served last wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_owner_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // clr gates req_ready so nothing reads as accepted while reset is held,
  // even though the state register already sits in IDLE.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi]  = clr & (state_reg == IDLE) & grant[gi];
      assign resp_valid[gi] = (state_reg == RESPOND) & (owner_reg == 1'(gi));
    end
  endgenerate

  assign busy        = (state_reg != IDLE);
  assign resp_result = result_reg;

  // Integer -> float cast of the held operand. The magnitude is normalised so
  // its leading one lands on bit 31; bits [30:8] are the mantissa, bit 7 is
  // the guard bit and bits [6:0] fold into sticky. A rounding carry out of
  // the 24-bit significand bumps the exponent and leaves a zero mantissa.
  logic        cast_sign;
  logic [31:0] cast_mag;
  logic [4:0]  lead;
  logic [31:0] norm;
  logic        round_up;
  logic [24:0] rounded;
  logic [7:0]  cast_exp;

  always_comb begin
    cast_sign = sgn_reg & opnd_reg[31];
    cast_mag  = cast_sign ? (~opnd_reg + 32'd1) : opnd_reg;
    lead      = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (cast_mag[i]) lead = 5'(i);
    end
    norm     = cast_mag << (5'd31 - lead);
    round_up = norm[7] & ((|norm[6:0]) | norm[8]);
    rounded  = {1'b0, norm[31:8]} + {24'd0, round_up};
    cast_exp = 8'd127 + {3'd0, lead} + {7'd0, rounded[24]};
    if (cast_mag == 32'd0)
      cast_result = 32'd0;
    else
      cast_result = {cast_sign, cast_exp,
                     rounded[24] ? rounded[23:1] : rounded[22:0]};
  end

  // Next-state and datapath loads.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    sgn_next        = sgn_reg;
    opnd_next       = opnd_reg;
    result_next     = result_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req_ready) begin
          owner_next = grant[1];
          opnd_next  = grant[1] ? req_operand1 : req_operand0;
          sgn_next   = grant[1] ? req_signed[1] : req_signed[0];
          cnt_next   = 3'(EXTRA_CYCLES);
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else begin
          result_next = cast_result;
          state_next  = RESPOND;
        end
      end
      RESPOND: begin
        // Only the owner's resp_ready completes the handshake.
        if (resp_ready[owner_reg]) begin
          last_owner_next = owner_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;   // requester 0 wins the first tie
      sgn_reg        <= 1'b0;
      opnd_reg       <= 32'd0;
      result_reg     <= 32'd0;
      cnt_reg        <= 3'd0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      sgn_reg        <= sgn_next;
      opnd_reg       <= opnd_next;
      result_reg     <= result_next;
      cnt_reg        <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fpu_cast_scheduler.sv
// Testbench for fpu_cast_scheduler: directed scenarios plus randomized
// transactions, each checked against a value-level reference cast and a
// transaction-level model of arbitration and latency.
module tb_fpu_cast_scheduler;

  localparam int EXTRA = 3;

  logic        clk;
  logic        clr;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_operand0;
  logic [31:0] req_operand1;
  logic [1:0]  req_signed;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int last_owner = 1;   // model: requester that was served last

  fpu_cast_scheduler #(.EXTRA_CYCLES(EXTRA)) dut (
    .clk         (clk),
    .clr         (clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operand0(req_operand0),
    .req_operand1(req_operand1),
    .req_signed  (req_signed),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference cast with 64-bit integer arithmetic: scale by 2^23 / 2^e and
  // round the remainder against half a unit in the last place.
  function automatic logic [31:0] ref_cast(input logic [31:0] op, input logic sg);
    logic neg;
    longint unsigned mag, scaled, q, rem, half;
    int e;
    neg = sg && op[31];
    mag = neg ? ((64'd1 << 32) - {32'd0, op}) : {32'd0, op};
    if (mag == 0) return 32'd0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    scaled = mag << 23;
    q      = scaled >> e;
    rem    = scaled - (q << e);
    if (e > 0) begin
      half = 64'd1 << (e - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    return {neg, 8'(127 + e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] specials [8];
    specials = '{32'h0, 32'h1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                 32'h01000001, 32'h01000003, 32'h00FFFFFF};
    case ($urandom_range(0, 3))
      0:       return specials[$urandom_range(0, 7)];
      1:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // One complete transaction, started and finished on a falling edge.
  task automatic run_txn(input logic [1:0] v, input logic [31:0] op0, input logic [31:0] op1,
                         input logic [1:0] sg, input int stall,
                         output int owner, output logic [31:0] res);
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    int lat;
    req_valid    = v;
    req_operand0 = op0;
    req_operand1 = op1;
    req_signed   = sg;
    resp_ready   = 2'b00;
    #1;
    if (v == 2'b11) exp_g = (last_owner == 1) ? 2'b01 : 2'b10;
    else            exp_g = v;
    check_val("idle_req_ready", 32'(req_ready), 32'(exp_g));
    check_val("idle_busy", 32'(busy), 32'd0);
    owner = exp_g[1] ? 1 : 0;
    exp_r = ref_cast(owner == 1 ? op1 : op0, sg[owner]);
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    // Inputs (including resp_ready) are scrambled during CONVERT; none of it
    // may influence the in-flight result.
    while (resp_valid == 2'b00 && lat < 30) begin
      check_val("conv_req_ready", 32'(req_ready), 32'd0);
      check_val("conv_busy", 32'(busy), 32'd1);
      req_valid    = 2'($urandom);
      req_operand0 = $urandom;
      req_operand1 = $urandom;
      req_signed   = 2'($urandom);
      resp_ready   = 2'($urandom);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_val("latency", 32'(lat), 32'(1 + EXTRA));
    res = resp_result;
    check_val("resp_valid", 32'(resp_valid), 32'(exp_g));
    check_val("result", resp_result, exp_r);
    for (int i = 0; i < stall; i++) begin
      resp_ready   = ~exp_g & 2'($urandom);
      req_valid    = 2'($urandom);
      req_operand0 = $urandom;
      req_operand1 = $urandom;
      #1;
      check_val("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_val("stall_resp_valid", 32'(resp_valid), 32'(exp_g));
      check_val("stall_result", resp_result, exp_r);
      check_val("stall_busy", 32'(busy), 32'd1);
    end
    resp_ready = exp_g | (2'($urandom) & ~exp_g);
    req_valid  = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_val("done_resp_valid", 32'(resp_valid), 32'd0);
    check_val("done_busy", 32'(busy), 32'd0);
    check_val("done_result_kept", resp_result, exp_r);
    last_owner = owner;
    resp_ready = 2'b00;
    $display("txn v=%b owner=%0d op=0x%08h sg=%b stall=%0d lat=%0d result=0x%08h",
             v, owner, (owner == 1) ? op1 : op0, sg[owner], stall, lat, res);
  endtask

  int          own;
  logic [31:0] res;

  initial begin
    clr          = 1'b0;
    req_valid    = 2'b11;
    req_operand0 = 32'h12345678;
    req_operand1 = 32'h9ABCDEF0;
    req_signed   = 2'b11;
    resp_ready   = 2'b11;

    // Reset state, with requests pending while clr is held low.
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_result", resp_result, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Tie right after reset: requester 0 first, then requester 1.
    // Acceptance happens on the first rising edge after release.
    run_txn(2'b11, 32'h00000001, 32'h80000000, 2'b10, 0, own, res);
    check_val("tie_first_owner", 32'(own), 32'd0);
    check_val("tie_first_result", res, 32'h3F800000);
    run_txn(2'b11, 32'h00000001, 32'h80000000, 2'b10, 0, own, res);
    check_val("tie_second_owner", 32'(own), 32'd1);
    check_val("tie_second_result", res, 32'hCF000000);
    run_txn(2'b11, 32'd5, 32'd6, 2'b00, 0, own, res);
    check_val("tie_third_owner", 32'(own), 32'd0);

    // Single requests and rounding corners.
    run_txn(2'b01, 32'hFFFFFFFF, 32'h0, 2'b01, 0, own, res);
    check_val("neg_one", res, 32'hBF800000);
    run_txn(2'b10, 32'h0, 32'h7FFFFFFF, 2'b10, 0, own, res);
    check_val("max_signed", res, 32'h4F000000);
    run_txn(2'b01, 32'hFFFFFFFF, 32'h0, 2'b00, 0, own, res);
    check_val("max_unsigned", res, 32'h4F800000);
    run_txn(2'b10, 32'h1, 32'h0, 2'b11, 0, own, res);
    check_val("zero", res, 32'h00000000);

    // Backpressure for 5 cycles in RESPOND.
    run_txn(2'b01, 32'h01000003, 32'h0, 2'b00, 5, own, res);
    check_val("bp_result", res, 32'h4B800002);

    // Reset in the middle of CONVERT.
    req_valid    = 2'b01;
    req_operand0 = 32'h00000123;
    req_signed   = 2'b00;
    @(posedge clk);
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    check_val("midrst_req_ready", 32'(req_ready), 32'd0);
    check_val("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_result", resp_result, 32'd0);
    @(negedge clk);
    clr       = 1'b1;
    req_valid = 2'b00;
    last_owner = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("postrst_resp_valid", 32'(resp_valid), 32'd0);
    end
    $display("reset mid-operation: in-flight request discarded");

    // Fairness: both requesters held valid for 6 transactions.
    for (int i = 0; i < 6; i++) begin
      run_txn(2'b11, rand_op(), rand_op(), 2'($urandom), 0, own, res);
      check_val("fair_owner", 32'(own), 32'(i % 2));
    end

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      run_txn(2'($urandom_range(1, 3)), rand_op(), rand_op(), 2'($urandom),
              $urandom_range(0, 3), own, res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
